bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 23 ++
 rtl/bin2bcd_seq_if.sv | 19 +
 rtl/bcd_add3.sv | 10 +
 rtl/bin2bcd_seq.sv | 109 ++++++++++
 tb/tb_bin2bcd_seq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int unsigned DEF_W = 14;
  localparam int unsigned DEF_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // 10^n, the smallest value that no longer fits in n BCD digits.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a producer and the BCD converter.
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int unsigned W = DEF_W,
  parameter int unsigned N = DEF_N
) ();

  logic           Start;
  logic [W-1:0]   Bin;
  logic [4*N-1:0] BCD;
  logic           Ovf;
  logic           Busy;
  logic           Done;

  modport master (output Start, output Bin, input BCD, input Ovf, input Busy, input Done);
  modport slave  (input Start, input Bin, output BCD, output Ovf, output Busy, output Done);

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Pre-shift correction so the doubled digit carries correctly into the next
  always_comb d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned W = DEF_W,
  parameter int unsigned N = DEF_N
) (
  input logic          Clock,
  input logic          Resetn,
  bin2bcd_seq_if.slave bus
);

  localparam int unsigned BW        = 4 * N;
  localparam int unsigned CW        = $clog2(W + 1);
  localparam logic [63:0] OVF_LIMIT = pow10(N);

  state_e         state_q, state_d;
  logic [W-1:0]   bin_q, bin_d;
  logic [BW-1:0]  work_q, work_d, work_adj;
  logic [BW-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_cap_q, ovf_cap_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  for (genvar g = 0; g < N; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d_i (work_q[4*g +: 4]),
      .d_o (work_adj[4*g +: 4])
    );
  end

  // Next-state and registered-output logic for the IDLE/SHIFT/DONE sequence
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    ovf_cap_d = ovf_cap_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          bin_d     = bus.Bin;
          work_d    = '0;
          ovf_cap_d = (64'(bus.Bin) >= OVF_LIMIT);
          cnt_d     = CW'(W);
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Truncating cast drops the bit shifted out of the top digit.
        work_d = BW'({work_adj, bin_q[W-1]});
        bin_d  = bin_q << 1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = work_q;
        ovf_d   = ovf_cap_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output flops; reset aborts any conversion in flight
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      ovf_cap_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      ovf_cap_q <= ovf_cap_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.BCD  = bcd_q;
  assign bus.Ovf  = ovf_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed scoreboard bench for bin2bcd_seq (W=14, N=4).
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.W(14), .N(4)) bus ();

  bin2bcd_seq #(.W(14), .N(4)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    int          bin;
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  // Reference: decimal digits of (v mod 10000) by repeated division.
  function automatic logic [15:0] model_bcd(input int v);
    int          r;
    logic [15:0] b;
    r = v % 10000;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every Done must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (bus.Done) begin
        check("done_gap", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          check("spurious_done", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("bcd", 32'(bus.BCD), 32'(e.bcd));
          check("ovf", 32'(bus.Ovf), 32'(e.ovf));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_done = bus.Done;
    end
  end

  task automatic push_exp(input int b, input int done_cyc);
    exp_t e;
    e.bin = b;
    e.bcd = model_bcd(b);
    e.ovf = (b >= 10000);
    e.cyc = done_cyc;
    sb.push_back(e);
  endtask

  // Drive one Start pulse; returns the cycle index of the accepting edge.
  task automatic start_conv(input int b, output int acc);
    bus.Start = 1'b1;
    bus.Bin   = 14'(b);
    @(posedge clk);
    #1;
    acc = cyc;
    bus.Start = 1'b0;
    push_exp(b, acc + 15);
  endtask

  // Wait (bounded) for the scoreboard to drain, counting Busy-high cycles.
  task automatic wait_drain(output int busy_cnt);
    busy_cnt = bus.Busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
      if (bus.Busy) busy_cnt++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #50000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int bc;
    rst_n     = 1'b1;
    bus.Start = 1'b0;
    bus.Bin   = '0;
    #2 rst_n  = 1'b0;
    #20;
    check("rst_bcd",  32'(bus.BCD),  32'd0);
    check("rst_ovf",  32'(bus.Ovf),  32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    start_conv(0, acc);
    wait_drain(bc);
    check("busy_cycles", 32'(bc), 32'd14);

    start_conv(1234, acc);
    wait_drain(bc);
    start_conv(9999, acc);
    wait_drain(bc);
    check("busy_cycles_9999", 32'(bc), 32'd14);
    start_conv(10000, acc);
    wait_drain(bc);
    start_conv(16383, acc);
    wait_drain(bc);

    // Start during SHIFT with a new Bin must be ignored.
    start_conv(42, acc);
    repeat (4) @(posedge clk);
    #1;
    bus.Start = 1'b1;
    bus.Bin   = 14'd77;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    wait_drain(bc);

    // Start held high: back-to-back conversions every W+2 cycles.
    bus.Start = 1'b1;
    bus.Bin   = 14'd5;
    @(posedge clk);
    #1;
    acc     = cyc;
    bus.Bin = 14'd58;
    push_exp(5, acc + 15);
    push_exp(58, acc + 31);
    repeat (16) @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bcd_hold", 32'(bus.BCD), 32'h0005);
    wait_drain(bc);

    // Reset mid-conversion aborts with no Done.
    start_conv(9999, acc);
    void'(sb.pop_back());
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_bcd",  32'(bus.BCD),  32'd0);
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_idle_busy", 32'(bus.Busy), 32'd0);

    start_conv(321, acc);
    wait_drain(bc);
    check("busy_after_reset", 32'(bc), 32'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
